// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (C) and the loader (L).
// One transaction in flight; the winning request is latched, sequenced, and a timeout aborts dead accesses.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_done,
   output logic          c_err,
   output logic [DW-1:0] c_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic          l_done,
   output logic          l_err,
   output logic [DW-1:0] l_rdata,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ready,
   output logic          busy,
   output logic [1:0]    state_dbg
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic PORT_C = 1'b0;
   localparam logic PORT_L = 1'b1;

   logic [1:0]    state_q, state_d;
   logic          last_gnt_q, last_gnt_d;
   logic          win_q, win_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          c_gnt_q, c_gnt_d;
   logic          l_gnt_q, l_gnt_d;
   logic [DW-1:0] c_rdata_q, c_rdata_d;
   logic [DW-1:0] l_rdata_q, l_rdata_d;
   logic          c_err_q, c_err_d;
   logic          l_err_q, l_err_d;
   logic          pick;
   logic [DW-1:0] resp_data;
   logic          resp_err;
   logic          resp_fire;

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      win_d      = win_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      c_gnt_d    = 1'b0;
      l_gnt_d    = 1'b0;
      c_rdata_d  = c_rdata_q;
      l_rdata_d  = l_rdata_q;
      c_err_d    = c_err_q;
      l_err_d    = l_err_q;
      pick       = PORT_C;
      resp_data  = '0;
      resp_err   = 1'b0;
      resp_fire  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // On a tie the port that did not win last time goes first.
            pick = (c_req && l_req) ? ~last_gnt_q : l_req;
            if (c_req || l_req) begin
               win_d      = pick;
               last_gnt_d = pick;
               we_d       = (pick == PORT_L) ? l_we    : c_we;
               addr_d     = (pick == PORT_L) ? l_addr  : c_addr;
               wdata_d    = (pick == PORT_L) ? l_wdata : c_wdata;
               c_gnt_d    = (pick == PORT_C);
               l_gnt_d    = (pick == PORT_L);
               cnt_d      = '0;
               state_d    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (m_ready) begin
               resp_fire = 1'b1;
               resp_data = we_q ? '0 : m_rdata;
               resp_err  = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               resp_fire = 1'b1;
               resp_data = '0;
               resp_err  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            if (resp_fire) begin
               state_d = S_RESP;
               if (win_q == PORT_L) begin
                  l_rdata_d = resp_data;
                  l_err_d   = resp_err;
               end else begin
                  c_rdata_d = resp_data;
                  c_err_d   = resp_err;
               end
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         last_gnt_q <= PORT_L;
         win_q      <= PORT_C;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         c_gnt_q    <= 1'b0;
         l_gnt_q    <= 1'b0;
         c_rdata_q  <= '0;
         l_rdata_q  <= '0;
         c_err_q    <= 1'b0;
         l_err_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         win_q      <= win_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         c_gnt_q    <= c_gnt_d;
         l_gnt_q    <= l_gnt_d;
         c_rdata_q  <= c_rdata_d;
         l_rdata_q  <= l_rdata_d;
         c_err_q    <= c_err_d;
         l_err_q    <= l_err_d;
      end
   end

   // Memory-side outputs decode straight from state so an async reset drops m_req at once.
   assign m_req     = (state_q == S_ACCESS);
   assign m_we      = m_req & we_q;
   assign m_addr    = m_req ? addr_q  : '0;
   assign m_wdata   = m_req ? wdata_q : '0;

   assign c_gnt     = c_gnt_q;
   assign l_gnt     = l_gnt_q;
   assign c_done    = (state_q == S_RESP) && (win_q == PORT_C);
   assign l_done    = (state_q == S_RESP) && (win_q == PORT_L);
   assign c_rdata   = c_rdata_q;
   assign l_rdata   = l_rdata_q;
   assign c_err     = c_err_q;
   assign l_err     = l_err_q;
   assign busy      = (state_q != S_IDLE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction table plus reset, tie and reset-mid-access sequences.
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          c_gnt, c_done, c_err;
  logic [DW-1:0] c_rdata;
  logic          l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] l_addr = '0;
  logic [DW-1:0] l_wdata = '0;
  logic          l_gnt, l_done, l_err;
  logic [DW-1:0] l_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [1:0]    state_dbg;

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_err(l_err), .l_rdata(l_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .state_dbg(state_dbg)
  );

  typedef struct {
    logic        port;       // 0 = C, 1 = L
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ready_cyc;  // ACCESS cycle (1-based) with m_ready=1; 0 = never
    logic [31:0] mem_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard state: what each port's response registers must hold
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_c_rdata, exp_l_rdata;
  logic          exp_c_err, exp_l_err;
  logic          exp_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_port(input logic port, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      l_req = req; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
    end
  endtask

  task automatic model_reset();
    exp_c_rdata = '0; exp_l_rdata = '0;
    exp_c_err = 1'b0; exp_l_err = 1'b0;
    exp_last = 1'b1;
  endtask

  // driver: one full transaction on one port, checked end to end
  task automatic do_txn(input vec_t v);
    logic got, addr_ok, done_seen, wrong, gnt_twice;
    int   k, mreq_cnt, exp_cnt;
    logic [DW-1:0] exp_data;
    drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
    m_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      got = v.port ? l_gnt : c_gnt;
    end
    check("gnt_seen", {31'b0, got}, 32'd1);
    check("gnt_other_zero", {31'b0, v.port ? c_gnt : l_gnt}, 32'd0);
    check("m_we", {31'b0, m_we}, {31'b0, v.we});
    check("m_wdata", m_wdata, v.wdata);
    // fields change after the grant; the latched copy must be used
    drive_port(v.port, 1'b0, ~v.we, ~v.addr, ~v.wdata);
    k = 0; mreq_cnt = 0; addr_ok = 1'b1; done_seen = 1'b0; wrong = 1'b0; gnt_twice = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (m_req) begin
        mreq_cnt++;
        k++;
        if (m_addr !== v.addr) addr_ok = 1'b0;
        m_ready = (k == v.ready_cyc);
        m_rdata = (k == v.ready_cyc) ? v.mem_data : $urandom;
      end else begin
        m_ready = 1'b0;
      end
      @(negedge clk);
      if (i == 0 && (c_gnt || l_gnt)) gnt_twice = 1'b1;
      if (v.port ? c_done : l_done) wrong = 1'b1;
      done_seen = v.port ? l_done : c_done;
    end
    m_ready = 1'b0;
    exp_cnt = (v.ready_cyc == 0) ? TIMEOUT : v.ready_cyc;
    exp_q.push_back(v.exp_rdata);
    exp_data = exp_q.pop_front();
    check("done_seen", {31'b0, done_seen}, 32'd1);
    check("gnt_one_cycle", {31'b0, gnt_twice}, 32'd0);
    check("m_addr_latched", {31'b0, addr_ok}, 32'd1);
    check("other_done_zero", {31'b0, wrong}, 32'd0);
    check("m_req_cycles", mreq_cnt, exp_cnt);
    check("rdata", v.port ? l_rdata : c_rdata, exp_data);
    check("err", {31'b0, v.port ? l_err : c_err}, {31'b0, v.exp_err});
    check("other_rdata_held", v.port ? c_rdata : l_rdata, v.port ? exp_c_rdata : exp_l_rdata);
    check("other_err_held", {31'b0, v.port ? c_err : l_err}, {31'b0, v.port ? exp_c_err : exp_l_err});
    if (v.port) begin exp_l_rdata = exp_data; exp_l_err = v.exp_err; end
    else        begin exp_c_rdata = exp_data; exp_c_err = v.exp_err; end
    exp_last = v.port;
    @(negedge clk);
    check("done_pulse_end", {30'b0, c_done, l_done}, 32'd0);
    check("idle_after", {31'b0, busy}, 32'd0);
    check("rdata_hold", v.port ? l_rdata : c_rdata, exp_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic exp_first, cur, wrong;
    int   gcnt;
    int   gcyc[4];
    logic gport[4];
    logic [31:0] flags;

    vecs[0] = '{1'b0, 1'b0, 32'h10,   32'h0,        2,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h40,   32'h13,       1,  32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h80,   32'hA5A5A5A5, 3,  32'h11111111, 32'h0,        1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h1234, 32'h0,        1,  32'h12345678, 32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h2000, 32'h0,        0,  32'h0,        32'h0,        1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h2004, 32'h0,        16, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h3000, 32'h0,        0,  32'h0,        32'h0,        1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h3004, 32'h0,        5,  32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0};

    // reset with random inputs: every output must read 0
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      c_req = 1'($urandom); c_we = 1'($urandom); c_addr = $urandom; c_wdata = $urandom;
      l_req = 1'($urandom); l_we = 1'($urandom); l_addr = $urandom; l_wdata = $urandom;
      m_ready = 1'($urandom); m_rdata = $urandom;
      @(negedge clk);
      flags = {23'b0, c_gnt, c_done, c_err, l_gnt, l_done, l_err, m_req, m_we, busy};
      check("reset_flags", flags, 32'd0);
      check("reset_buses", c_rdata | l_rdata | m_addr | m_wdata, 32'd0);
    end
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    m_ready = 1'b0; m_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_release", {29'b0, busy, state_dbg}, 32'd0);

    // tie: both requesters hold req, memory always ready
    exp_first = ~exp_last;
    c_addr = 32'h100; l_addr = 32'h200;
    c_req = 1'b1; l_req = 1'b1; m_ready = 1'b1; m_rdata = 32'h55AA55AA;
    gcnt = 0; cur = exp_first; wrong = 1'b0;
    for (int i = 0; i < 4; i++) begin gcyc[i] = 0; gport[i] = 1'bx; end
    for (int cyc = 0; cyc < 30 && gcnt < 4; cyc++) begin
      @(negedge clk);
      if (c_gnt && l_gnt) wrong = 1'b1;
      if (c_gnt || l_gnt) begin
        gport[gcnt] = l_gnt; gcyc[gcnt] = cyc; cur = l_gnt; gcnt++;
      end
      if (cur == 1'b0 && (l_gnt || l_done)) wrong = 1'b1;
      if (cur == 1'b1 && (c_gnt || c_done)) wrong = 1'b1;
    end
    c_req = 1'b0; l_req = 1'b0;
    check("tie_grants", gcnt, 4);
    check("tie_order", {28'b0, gport[0], gport[1], gport[2], gport[3]},
          {28'b0, exp_first, ~exp_first, exp_first, ~exp_first});
    check("tie_spacing", {gcyc[1] - gcyc[0], gcyc[2] - gcyc[1], gcyc[3] - gcyc[2]} == {32'd3, 32'd3, 32'd3}, 32'd1);
    check("tie_no_cross", {31'b0, wrong}, 32'd0);
    repeat (2) @(negedge clk);
    m_ready = 1'b0;
    check("tie_idle", {31'b0, busy}, 32'd0);
    check("tie_c_rdata", c_rdata, 32'h55AA55AA);
    check("tie_l_rdata", l_rdata, 32'h55AA55AA);
    exp_c_rdata = 32'h55AA55AA; exp_l_rdata = 32'h55AA55AA;
    exp_last = ~exp_first;

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // reset on the 3rd ACCESS cycle: m_req drops at once, no done afterwards
    drive_port(1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
    m_ready = 1'b0;
    gcnt = 0;
    for (int i = 0; i < 6 && gcnt == 0; i++) begin
      @(negedge clk);
      if (c_gnt) gcnt = 1;
    end
    check("rst_mid_gnt", gcnt, 1);
    c_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_mreq_before", {31'b0, m_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_mreq_async", {31'b0, m_req}, 32'd0);
    check("rst_mid_busy_async", {31'b0, busy}, 32'd0);
    model_reset();
    wrong = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (c_done || l_done) wrong = 1'b1;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (c_done || l_done || busy) wrong = 1'b1;
    end
    check("rst_mid_no_done", {31'b0, wrong}, 32'd0);
    check("rst_mid_rdata_clear", c_rdata, 32'h0);
    do_txn('{1'b0, 1'b0, 32'h600, 32'h0, 1, 32'h0BADF00D, 32'h0BADF00D, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
